multicycle_shifter: RTL and testbench

Parametrised iterative shifter for the processor's ALU/multdiv path. It supports four shift modes: logical left, logical right, arithmetic right and rotate right. It performs up to STEP bit positions per clock, so a full-range shift takes a bounded number of cycles instead of a wide combinational barrel. It sits beside the multdiv unit and uses the same start/ready handshake, so the pipeline can stall on it the same way.

---
 rtl/multicycle_shifter.sv | 109 ++++++++++
 tb/tb_multicycle_shifter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_shifter.sv
// Iterative shifter: SLL/SRL/SRA/ROR, up to STEP bit positions per clock,
// with the multdiv-style start/ready handshake.
module multicycle_shifter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH),
  parameter int unsigned STEP    = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ctrl_shift,
  input  logic [1:0]         shift_mode,
  input  logic [WIDTH-1:0]   data_operand,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   result,
  output logic               data_resultRDY,
  output logic               busy
);

  localparam int unsigned REM_W = SHAMT_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [1:0] MODE_SLL = 2'd0;
  localparam logic [1:0] MODE_SRL = 2'd1;
  localparam logic [1:0] MODE_SRA = 2'd2;

  logic [1:0]       state, state_d;
  logic [WIDTH-1:0] acc, acc_d, stepped;
  logic [REM_W-1:0] remaining, remaining_d, step_k;
  logic [1:0]       mode, mode_d;
  logic             busy_d, rdy_d;

  // One SHIFT edge: apply single-bit shifts while fewer than `remaining` done.
  always_comb begin
    stepped = acc;
    for (int unsigned i = 0; i < STEP; i++) begin
      if (REM_W'(i) < remaining) begin
        case (mode)
          MODE_SLL: stepped = {stepped[WIDTH-2:0], 1'b0};
          MODE_SRL: stepped = {1'b0, stepped[WIDTH-1:1]};
          MODE_SRA: stepped = {stepped[WIDTH-1], stepped[WIDTH-1:1]};
          default:  stepped = {stepped[0], stepped[WIDTH-1:1]};
        endcase
      end
    end
    step_k = (remaining < REM_W'(STEP)) ? remaining : REM_W'(STEP);
  end

  // Next-state and next-register logic.
  always_comb begin
    state_d     = state;
    acc_d       = acc;
    remaining_d = remaining;
    mode_d      = mode;
    busy_d      = 1'b0;
    rdy_d       = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (ctrl_shift) begin
          acc_d       = data_operand;
          remaining_d = REM_W'(shamt);
          mode_d      = shift_mode;
          if (shamt != '0) begin
            state_d = ST_SHIFT;
            busy_d  = 1'b1;
          end else begin
            state_d = ST_DONE;
            rdy_d   = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        acc_d       = stepped;
        remaining_d = remaining - step_k;
        if (remaining_d == '0) begin
          state_d = ST_DONE;
          rdy_d   = 1'b1;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      acc            <= '0;
      remaining      <= '0;
      mode           <= MODE_SLL;
      busy           <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      state          <= state_d;
      acc            <= acc_d;
      remaining      <= remaining_d;
      mode           <= mode_d;
      busy           <= busy_d;
      data_resultRDY <= rdy_d;
    end
  end

  assign result = acc;

endmodule

// File: tb/tb_multicycle_shifter.sv
// Self-checking bench: three shifters (STEP = 1, 4, 32) checked cycle by
// cycle against an arithmetic reference of the shift result and latency.
module tb_multicycle_shifter;

  logic        clk;
  logic        rst_n;
  logic        ctrl_a   [3];
  logic [1:0]  mode_a   [3];
  logic [31:0] op_a     [3];
  logic [4:0]  shamt_a  [3];
  logic [31:0] result_a [3];
  logic        rdy_a    [3];
  logic        busy_a   [3];

  int tests = 0;
  int fails = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned S = (g == 0) ? 1 : (g == 1) ? 4 : 32;
    multicycle_shifter #(.WIDTH(32), .STEP(S)) dut (
      .clock         (clk),
      .reset         (rst_n),
      .ctrl_shift    (ctrl_a[g]),
      .shift_mode    (mode_a[g]),
      .data_operand  (op_a[g]),
      .shamt         (shamt_a[g]),
      .result        (result_a[g]),
      .data_resultRDY(rdy_a[g]),
      .busy          (busy_a[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int step_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 4 : 32;
  endfunction

  // Reference: the whole shift done at once with SV operators.
  function automatic logic [31:0] model(input logic [1:0] m, input logic [31:0] op, input int sh);
    logic [63:0] dbl;
    case (m)
      2'd0:    return op << sh;
      2'd1:    return op >> sh;
      2'd2:    return 32'($signed(op) >>> sh);
      default: begin
        dbl = {op, op} >> sh;
        return dbl[31:0];
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a start at the current time; it is sampled on the next posedge.
  task automatic start(input int d, input logic [1:0] m, input logic [31:0] op, input int sh);
    ctrl_a[d]  = 1'b1;
    mode_a[d]  = m;
    op_a[d]    = op;
    shamt_a[d] = 5'(sh);
    @(posedge clk);
    #1 ctrl_a[d] = 1'b0;
  endtask

  // Check cycles 1..n+1 after a start; optionally pulse a stray start in cycle `pulse`.
  task automatic wait_op(input int d, input int n, input logic [31:0] exp, input int pulse);
    for (int c = 1; c <= n + 1; c++) begin
      @(negedge clk);
      chk($sformatf("busy s%0d c%0d", step_of(d), c), 32'(busy_a[d]), 32'(c <= n));
      chk($sformatf("rdy s%0d c%0d", step_of(d), c), 32'(rdy_a[d]), 32'(c == n + 1));
      if (c == n + 1) chk($sformatf("result s%0d", step_of(d)), result_a[d], exp);
      if (pulse != 0 && c == pulse) begin
        ctrl_a[d]  = 1'b1;
        op_a[d]    = 32'h1234_5678;
        mode_a[d]  = 2'd0;
        shamt_a[d] = 5'd3;
      end
      if (pulse != 0 && c == pulse + 1) ctrl_a[d] = 1'b0;
    end
  endtask

  task automatic run_op(input int d, input logic [1:0] m, input logic [31:0] op, input int sh,
                        output logic [31:0] res);
    logic [31:0] exp;
    int n;
    exp = model(m, op, sh);
    n   = (sh + step_of(d) - 1) / step_of(d);
    @(negedge clk);
    start(d, m, op, sh);
    wait_op(d, n, exp, 0);
    res = result_a[d];
    @(negedge clk);
    chk($sformatf("hold rdy s%0d", step_of(d)), 32'(rdy_a[d]), 32'd0);
    chk($sformatf("hold busy s%0d", step_of(d)), 32'(busy_a[d]), 32'd0);
    chk($sformatf("hold result s%0d", step_of(d)), result_a[d], exp);
  endtask

  initial begin
    logic [31:0] res;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      ctrl_a[d] = 1'b0; mode_a[d] = 2'd0; op_a[d] = 32'h0; shamt_a[d] = 5'd0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("reset result", result_a[d], 32'd0);
      chk("reset busy", 32'(busy_a[d]), 32'd0);
      chk("reset rdy", 32'(rdy_a[d]), 32'd0);
    end
    // Start requested while reset is held must be ignored.
    ctrl_a[0] = 1'b1; op_a[0] = 32'hFFFF_FFFF; shamt_a[0] = 5'd5;
    @(negedge clk);
    chk("reset wins busy", 32'(busy_a[0]), 32'd0);
    chk("reset wins result", result_a[0], 32'd0);
    ctrl_a[0] = 1'b0;
    rst_n = 1'b1;

    // Directed suite on each STEP.
    for (int d = 0; d < 3; d++) begin
      run_op(d, 2'd2, 32'h8000_0000, 1, res);  chk("sra1 const", res, 32'hC000_0000);
      run_op(d, 2'd2, 32'h8000_0000, 31, res); chk("sra31 const", res, 32'hFFFF_FFFF);
      run_op(d, 2'd1, 32'h8000_0000, 31, res); chk("srl31 const", res, 32'h0000_0001);
      run_op(d, 2'd3, 32'h0000_0001, 4, res);  chk("ror4 const", res, 32'h1000_0000);
      run_op(d, 2'd0, 32'h0000_0001, 31, res); chk("sll31 const", res, 32'h8000_0000);
      for (int m = 0; m < 4; m++) begin
        run_op(d, 2'(m), 32'hDEAD_BEEF, 0, res); chk("shamt0 const", res, 32'hDEAD_BEEF);
      end
    end

    // Randomized operations against the reference.
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 20; i++) begin
        run_op(d, 2'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, 31)), res);
      end
    end

    // Start during SHIFT is ignored, then a start in the DONE cycle runs with no gap.
    @(negedge clk);
    start(0, 2'd1, 32'hF000_0000, 8);
    wait_op(0, 8, 32'h00F0_0000, 3);
    start(0, 2'd2, 32'h8000_0000, 4);
    wait_op(0, 4, 32'hF800_0000, 0);
    @(negedge clk);
    chk("b2b idle rdy", 32'(rdy_a[0]), 32'd0);

    // Asynchronous reset mid-shift discards the operation.
    @(negedge clk);
    start(0, 2'd0, 32'h0000_0001, 20);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("pre-reset busy c%0d", c), 32'(busy_a[0]), 32'd1);
    end
    rst_n = 1'b0;
    #1;
    chk("async rst result", result_a[0], 32'd0);
    chk("async rst busy", 32'(busy_a[0]), 32'd0);
    chk("async rst rdy", 32'(rdy_a[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      chk("post-reset rdy", 32'(rdy_a[0]), 32'd0);
      chk("post-reset busy", 32'(busy_a[0]), 32'd0);
    end
    run_op(0, 2'd0, 32'h0000_0001, 20, res);
    chk("post-reset op const", res, 32'h0010_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
